// File: rtl/vga_blank_scheduler.sv
// vga_blank_scheduler: round-robin owner of the VGA register/palette write port
// during vertical blanking. Each grant is one-hot, registered, at most MAX_BURST
// cycles long, and is revoked (with an overrun pulse) if active video resumes
// while a requester still holds it.
// Optional build macro VGA_SCHED_STATS_EN adds grant_count, the number of grants
// issued in the current frame (saturating at 255).
module vga_blank_scheduler #(
    parameter int N         = 4,
    parameter int MAX_BURST = 8,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank,
    input  logic [N-1:0]       req,
    output logic [N-1:0]       grant,
    output logic               busy,
    output logic               overrun,
`ifdef VGA_SCHED_STATS_EN
    output logic [7:0]         grant_count,
`endif
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, ARB, GRANT, GAP} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gidx;
    logic [CNT_W-1:0] cnt;
    logic             vblank_q;
    logic             vblank_rise;
    logic             pick_vld;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] nxt_ptr;

    assign vblank_rise = vblank && !vblank_q;
    assign busy        = |grant;
    assign nxt_ptr     = (gidx == PTR_LAST) ? '0 : gidx + 1'b1;

    // Round-robin pick: scan downward so the smallest offset from rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % N]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'((int'(rr_ptr) + k) % N);
            end
        end
    end

    // Blanking edge detector and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_q  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vblank_q <= vblank;
            if (vblank_rise)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Arbitration FSM; grant, overrun and the round-robin pointer are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            overrun <= 1'b0;
            rr_ptr  <= '0;
            gidx    <= '0;
            cnt     <= '0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (vblank)
                        state <= ARB;
                end
                ARB: begin
                    if (!vblank) begin
                        state <= IDLE;
                    end else if (pick_vld) begin
                        grant <= N'(1) << pick_idx;
                        gidx  <= pick_idx;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped request is a clean release even if video resumes on the same edge.
                    if (!req[gidx]) begin
                        grant  <= '0;
                        rr_ptr <= nxt_ptr;
                        state  <= GAP;
                    end else if (!vblank) begin
                        grant   <= '0;
                        overrun <= 1'b1;
                        rr_ptr  <= nxt_ptr;
                        state   <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        grant  <= '0;
                        rr_ptr <= nxt_ptr;
                        state  <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= vblank ? ARB : IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VGA_SCHED_STATS_EN
    // Per-frame grant statistics; a new frame clears the count before any grant in it.
    always_ff @(posedge clk) begin
        if (rst)
            grant_count <= '0;
        else if (vblank_rise)
            grant_count <= '0;
        else if (state == ARB && vblank && pick_vld && grant_count != 8'hFF)
            grant_count <= grant_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_vga_blank_scheduler.sv
// Self-checking bench for vga_blank_scheduler (N=4, MAX_BURST=4).
// Expected grant/overrun values are queued as stimulus is driven and popped
// after the corresponding clock edge.
module tb_vga_blank_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       vblank;
    logic [3:0] req;
    logic [3:0] grant;
    logic       busy;
    logic       overrun;
    logic [7:0] frame_cnt;
`ifdef VGA_SCHED_STATS_EN
    logic [7:0] grant_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic       ov;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    vga_blank_scheduler #(.N(4), .MAX_BURST(4), .FRAME_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .vblank     (vblank),
        .req        (req),
        .grant      (grant),
        .busy       (busy),
        .overrun    (overrun),
`ifdef VGA_SCHED_STATS_EN
        .grant_count(grant_count),
`endif
        .frame_cnt  (frame_cnt)
    );

    // Drive inputs for the next edge and queue what the outputs must be after it.
    task automatic drive(input logic r, input logic vb, input logic [3:0] rq,
                         input logic [3:0] eg, input logic eo);
        exp_t e;
        rst    = r;
        vblank = vb;
        req    = rq;
        e.g    = eg;
        e.ov   = eo;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; vblank = 1'b0; req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || overrun !== e.ov || busy !== 1'b0 || frame_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset cyc %0d grant=%b ov=%b busy=%b frame=%0d want 0000/0/0/0",
                         k, grant, overrun, busy, frame_cnt);
            end
        end
    endtask

    task automatic test_idle_ignore();
        exp_t e;
        for (int k = 0; k < 22; k++) begin
            if (k < 20)       drive(1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
            else if (k == 20) drive(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0);
            else              drive(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || overrun !== e.ov || busy !== (|e.g)) begin
                errors++;
                $display("FAIL idle_ignore cyc %0d grant=%b ov=%b busy=%b want grant=%b ov=%b",
                         k, grant, overrun, busy, e.g, e.ov);
            end
        end
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL idle_frame_cnt got %0d want 1", frame_cnt);
        end
    endtask

    // Bursts of 4, then GAP and ARB give two idle cycles before the next owner.
    task automatic test_round_robin();
        exp_t e;
        logic [3:0] eg[$];
        do_reset();
        eg.push_back(4'b0000);
        for (int gi = 0; gi < 4; gi++) begin
            for (int b = 0; b < 4; b++) eg.push_back(4'b0001 << gi);
            eg.push_back(4'b0000);
            eg.push_back(4'b0000);
        end
        eg.push_back(4'b0001);
        for (int k = 0; k < eg.size(); k++) begin
            drive(1'b0, 1'b1, 4'hF, eg[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || overrun !== e.ov || busy !== (|e.g)) begin
                errors++;
                $display("FAIL round_robin cyc %0d grant=%b ov=%b busy=%b want grant=%b ov=%b",
                         k, grant, overrun, busy, e.g, e.ov);
            end
        end
    endtask

    task automatic test_req_drop();
        exp_t e;
        logic [3:0] rq[8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1100, 4'b1100, 4'b1100};
        logic [3:0] eg[8] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, rq[k], eg[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || overrun !== e.ov || busy !== (|e.g)) begin
                errors++;
                $display("FAIL req_drop cyc %0d grant=%b ov=%b busy=%b want grant=%b ov=%b",
                         k, grant, overrun, busy, e.g, e.ov);
            end
        end
    endtask

    task automatic test_overrun();
        exp_t e;
        logic       vb[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] rq[10] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
        logic [3:0] eg[10] = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
        logic       eo[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, vb[k], rq[k], eg[k], eo[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || overrun !== e.ov || busy !== (|e.g)) begin
                errors++;
                $display("FAIL overrun cyc %0d grant=%b ov=%b busy=%b want grant=%b ov=%b",
                         k, grant, overrun, busy, e.g, e.ov);
            end
        end
        checks++;
        if (frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overrun_frame_cnt got %0d want 2", frame_cnt);
        end
    endtask

    // Reset while a grant is held, with vblank falling on the same edge.
    task automatic test_reset_mid();
        exp_t e;
        logic       r[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       vb[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] eg[4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(r[k], vb[k], 4'b0010, eg[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || overrun !== e.ov || busy !== (|e.g)) begin
                errors++;
                $display("FAIL reset_mid cyc %0d grant=%b ov=%b busy=%b want grant=%b ov=%b",
                         k, grant, overrun, busy, e.g, e.ov);
            end
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_frame_cnt got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_stats();
`ifdef VGA_SCHED_STATS_EN
        do_reset();
        rst = 1'b0; vblank = 1'b1; req = 4'hF;
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (grant_count !== 8'd3) begin
            errors++;
            $display("FAIL stats_count got %0d want 3", grant_count);
        end
        vblank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (grant_count !== 8'd3) begin
            errors++;
            $display("FAIL stats_hold got %0d want 3", grant_count);
        end
        vblank = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (grant_count !== 8'd0) begin
            errors++;
            $display("FAIL stats_clear got %0d want 0", grant_count);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; vblank = 1'b0; req = '0;
        test_reset();
        test_idle_ignore();
        test_round_robin();
        test_req_drop();
        test_overrun();
        test_reset_mid();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
